// File: rtl/fpu_ss_core_arbiter_if.sv
// Bundle of the per-core issue/result handshakes and the shared FPU subsystem port.
// slave is the arbiter's view; master is the cores/subsystem side.
interface fpu_ss_core_arbiter_if #(
   parameter int NB_CORES = 8
);
   logic [NB_CORES-1:0] core_issue_valid_i;
   logic [NB_CORES-1:0] core_issue_ready_o;
   logic                ss_issue_valid_o;
   logic                ss_issue_ready_i;
   logic [31:0]         core_id_o;
   logic                ss_result_valid_i;
   logic [31:0]         ss_result_core_id_i;
   logic                ss_result_ready_o;
   logic [NB_CORES-1:0] core_result_valid_o;
   logic [NB_CORES-1:0] core_result_ready_i;
   logic                busy_o;
   logic                err_o;

   modport slave (
      input  core_issue_valid_i, ss_issue_ready_i, ss_result_valid_i,
             ss_result_core_id_i, core_result_ready_i,
      output core_issue_ready_o, ss_issue_valid_o, core_id_o,
             ss_result_ready_o, core_result_valid_o, busy_o, err_o
   );

   modport master (
      output core_issue_valid_i, ss_issue_ready_i, ss_result_valid_i,
             ss_result_core_id_i, core_result_ready_i,
      input  core_issue_ready_o, ss_issue_valid_o, core_id_o,
             ss_result_ready_o, core_result_valid_o, busy_o, err_o
   );
endinterface

// File: rtl/fpu_ss_core_arbiter.sv
// Round-robin sharing of one FPU subsystem between NB_CORES cores, with result
// demux by core ID and per-core outstanding-instruction throttling.
module fpu_ss_core_arbiter #(
   parameter int NB_CORES        = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   fpu_ss_core_arbiter_if.slave bus
);
   localparam int IW = $clog2(NB_CORES);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned NB = NB_CORES;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
   localparam logic [IW-1:0] LAST_ID = IW'(NB_CORES - 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   lock_id;
   logic [CW-1:0]   cnt [NB_CORES];
   logic            err;

   logic [NB_CORES-1:0] elig;
   logic [NB_CORES-1:0] nonzero;
   logic [NB_CORES-1:0] cnt_inc;
   logic [NB_CORES-1:0] cnt_dec;
   logic [IW-1:0]       gnt;
   logic [IW-1:0]       winner;
   logic [IW-1:0]       rid;
   logic                issue_valid;
   logic                issue_hs;
   logic                rid_legal;
   logic                result_ready;
   logic                result_hs;
   logic                err_set;

   always_comb begin
      for (int unsigned i = 0; i < NB; i++) begin
         elig[i]    = bus.core_issue_valid_i[i] && (cnt[i] != CNT_MAX);
         nonzero[i] = (cnt[i] != '0);
      end
   end

   // First eligible core at or above rr_ptr, wrapping around.
   always_comb begin
      int unsigned   idx;
      logic [IW-1:0] idx_w;
      logic          found;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      idx_w = '0;
      for (int unsigned off = 0; off < NB; off++) begin
         idx   = (32'(rr_ptr) + off) % NB;
         idx_w = IW'(idx);
         if (!found && elig[idx_w]) begin
            gnt   = idx_w;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      winner      = (state == LOCKED) ? lock_id : gnt;
      issue_valid = (state == LOCKED) || (|elig);
      issue_hs    = issue_valid && bus.ss_issue_ready_i;

      bus.ss_issue_valid_o   = issue_valid;
      bus.core_id_o          = 32'(winner);
      bus.core_issue_ready_o = '0;
      if (issue_valid) bus.core_issue_ready_o[winner] = bus.ss_issue_ready_i;
   end

   // Illegal result IDs are always accepted and dropped.
   always_comb begin
      rid_legal    = bus.ss_result_core_id_i < 32'(NB_CORES);
      rid          = bus.ss_result_core_id_i[IW-1:0];
      result_ready = 1'b1;
      bus.core_result_valid_o = '0;
      if (rid_legal) begin
         bus.core_result_valid_o[rid] = bus.ss_result_valid_i;
         result_ready = bus.core_result_ready_i[rid];
      end
      result_hs = bus.ss_result_valid_i && result_ready && rid_legal;
      bus.ss_result_ready_o = result_ready;
   end

   always_comb begin
      err_set = bus.ss_result_valid_i && !rid_legal;
      for (int unsigned i = 0; i < NB; i++) begin
         cnt_inc[i] = issue_hs && (winner == IW'(i));
         cnt_dec[i] = result_hs && (rid == IW'(i));
         if (cnt_dec[i] && (cnt[i] == '0)) err_set = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         lock_id <= '0;
         err     <= 1'b0;
         for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue_valid && !bus.ss_issue_ready_i) begin
                  state   <= LOCKED;
                  lock_id <= gnt;
               end
            end
            LOCKED: begin
               if (bus.ss_issue_ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (issue_hs) rr_ptr <= (winner == LAST_ID) ? '0 : winner + 1'b1;
         if (err_set) err <= 1'b1;

         // Simultaneous issue and result on one core cancel out.
         for (int unsigned i = 0; i < NB; i++) begin
            if (cnt_inc[i] && !cnt_dec[i]) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else if (cnt_dec[i] && !cnt_inc[i] && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   assign bus.busy_o = |nonzero;
   assign bus.err_o  = err;
endmodule

// File: tb/tb_fpu_ss_core_arbiter.sv
// Scoreboard bench for fpu_ss_core_arbiter: stimulus queues expected grants and
// result routings, a negedge monitor pops and compares on every handshake.
module tb_fpu_ss_core_arbiter;
   localparam int NB = 8;
   localparam int MO = 4;

   typedef struct {
      logic [NB-1:0] valid;
      logic          ready;
   } res_t;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   fpu_ss_core_arbiter_if #(.NB_CORES(NB)) bus ();

   fpu_ss_core_arbiter #(.NB_CORES(NB), .MAX_OUTSTANDING(MO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int   exp_issue_q[$];
   res_t exp_res_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   mon_e;
   res_t mon_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.core_issue_valid_i  = '0;
      bus.ss_issue_ready_i    = 1'b0;
      bus.ss_result_valid_i   = 1'b0;
      bus.ss_result_core_id_i = '0;
      bus.core_result_ready_i = '0;
   endtask

   task automatic set_issue(input logic [NB-1:0] v, input logic rdy);
      bus.core_issue_valid_i = v;
      bus.ss_issue_ready_i   = rdy;
   endtask

   task automatic set_result(input logic vld, input int rid, input logic [NB-1:0] rdy);
      bus.ss_result_valid_i   = vld;
      bus.ss_result_core_id_i = 32'(rid);
      bus.core_result_ready_i = rdy;
   endtask

   task automatic push_res(input logic [NB-1:0] v, input logic rdy);
      res_t r;
      r.valid = v;
      r.ready = rdy;
      exp_res_q.push_back(r);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      idle_inputs();
      repeat (2) cyc();
      rst_ni = 1'b1;
      cyc();
   endtask

   // Drains n outstanding results for one core, one per cycle.
   task automatic drain(input int core, input int n);
      set_issue('0, 1'b0);
      for (int k = 0; k < n; k++) begin
         set_result(1'b1, core, '1);
         push_res(NB'(1) << core, 1'b1);
         cyc();
      end
      set_result(1'b0, 0, '0);
   endtask

   always @(negedge clk) begin
      if (rst_ni) begin
         if (bus.ss_issue_valid_o && bus.ss_issue_ready_i) begin
            if (exp_issue_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL issue_unexpected: got grant to core %0d, expected no handshake at %0t",
                        bus.core_id_o, $time);
            end else begin
               mon_e = exp_issue_q.pop_front();
               check("issue_core_id", bus.core_id_o, 32'(mon_e));
            end
         end
         if (bus.ss_result_valid_i) begin
            if (exp_res_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL result_unexpected: got result for id %0d, expected none at %0t",
                        bus.ss_result_core_id_i, $time);
            end else begin
               mon_r = exp_res_q.pop_front();
               check("result_core_valid", 32'(bus.core_result_valid_o), 32'(mon_r.valid));
               check("result_ss_ready", 32'(bus.ss_result_ready_o), 32'(mon_r.ready));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      cyc();
      mid();
      check("rst_busy", 32'(bus.busy_o), 32'h0);
      check("rst_err", 32'(bus.err_o), 32'h0);
      check("rst_issue_valid", 32'(bus.ss_issue_valid_o), 32'h0);
      check("rst_issue_ready", 32'(bus.core_issue_ready_o), 32'h0);
      check("rst_result_valid", 32'(bus.core_result_valid_o), 32'h0);
      check("rst_result_ready", 32'(bus.ss_result_ready_o), 32'h0);
      cyc();
      rst_ni = 1'b1;
      cyc();

      // Lock under backpressure: cores 2 and 5, ready low for 3 cycles.
      exp_issue_q.push_back(2);
      exp_issue_q.push_back(5);
      for (int c = 0; c < 4; c++) begin
         set_issue(8'h24, c == 3);
         mid();
         check("lock_core_id", bus.core_id_o, 32'd2);
         check("lock_valid", 32'(bus.ss_issue_valid_o), 32'h1);
         check("lock_core_ready", 32'(bus.core_issue_ready_o), (c == 3) ? 32'h04 : 32'h00);
         cyc();
      end
      set_issue(8'h24, 1'b1);
      mid();
      check("lock_next_grant", bus.core_id_o, 32'd5);
      cyc();
      idle_inputs();
      mid();
      check("lock_busy", 32'(bus.busy_o), 32'h1);
      cyc();
      drain(2, 1);
      drain(5, 1);
      mid();
      check("lock_busy_clear", 32'(bus.busy_o), 32'h0);
      cyc();

      // Round-robin rotation, results returned the following cycle.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         set_issue((c < 9) ? 8'hFF : 8'h00, 1'b1);
         if (c < 9) exp_issue_q.push_back(c % NB);
         if (c >= 1) begin
            set_result(1'b1, (c - 1) % NB, '1);
            push_res(NB'(1) << ((c - 1) % NB), 1'b1);
         end else begin
            set_result(1'b0, 0, '0);
         end
         cyc();
      end
      idle_inputs();
      mid();
      check("rr_busy_clear", 32'(bus.busy_o), 32'h0);
      cyc();

      // Throttle: core 3 alone, no results until the counter saturates.
      for (int c = 0; c < 7; c++) begin
         set_issue(8'h08, 1'b1);
         set_result(1'b0, 0, '0);
         if (c < 4 || c == 6) exp_issue_q.push_back(3);
         if (c == 5) begin
            set_result(1'b1, 3, '1);
            push_res(8'h08, 1'b1);
         end
         mid();
         if (c == 4) check("thr_valid_off", 32'(bus.ss_issue_valid_o), 32'h0);
         if (c == 5) check("thr_valid_off_hs", 32'(bus.ss_issue_valid_o), 32'h0);
         if (c == 6) check("thr_valid_back", 32'(bus.ss_issue_valid_o), 32'h1);
         cyc();
      end
      drain(3, MO);
      mid();
      check("thr_busy_clear", 32'(bus.busy_o), 32'h0);
      cyc();

      // Simultaneous issue and result on core 1 with cnt = 2.
      for (int c = 0; c < 3; c++) begin
         set_issue(8'h02, 1'b1);
         exp_issue_q.push_back(1);
         if (c == 2) begin
            set_result(1'b1, 1, '1);
            push_res(8'h02, 1'b1);
         end
         cyc();
      end
      set_result(1'b0, 0, '0);
      set_issue(8'h02, 1'b1);
      exp_issue_q.push_back(1);
      mid();
      check("sim_busy", 32'(bus.busy_o), 32'h1);
      cyc();
      exp_issue_q.push_back(1);
      cyc();
      mid();
      check("sim_cnt_full", 32'(bus.ss_issue_valid_o), 32'h0);
      cyc();
      drain(1, MO);

      // Result routing with backpressure, then an illegal ID.
      set_issue(8'h40, 1'b1);
      exp_issue_q.push_back(6);
      cyc();
      set_issue('0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         set_result(1'b1, 6, (c == 2) ? 8'h40 : 8'h00);
         push_res(8'h40, c == 2);
         cyc();
      end
      set_result(1'b1, 9, '0);
      push_res(8'h00, 1'b1);
      mid();
      check("err_clean", 32'(bus.err_o), 32'h0);
      cyc();
      idle_inputs();
      mid();
      check("err_set", 32'(bus.err_o), 32'h1);
      check("err_busy_clear", 32'(bus.busy_o), 32'h0);
      repeat (3) cyc();
      mid();
      check("err_sticky", 32'(bus.err_o), 32'h1);
      cyc();

      // Async reset while LOCKED with a nonzero counter.
      set_issue(8'h10, 1'b1);
      exp_issue_q.push_back(4);
      cyc();
      set_issue(8'h10, 1'b0);
      mid();
      check("ar_locked_id", bus.core_id_o, 32'd4);
      cyc();
      set_issue(8'h11, 1'b0);
      mid();
      check("ar_lock_hold", bus.core_id_o, 32'd4);
      cyc();
      #2;
      rst_ni = 1'b0;
      #1;
      check("ar_busy", 32'(bus.busy_o), 32'h0);
      check("ar_err", 32'(bus.err_o), 32'h0);
      check("ar_unlock", bus.core_id_o, 32'd0);
      idle_inputs();
      repeat (2) cyc();
      rst_ni = 1'b1;
      set_issue(8'hFF, 1'b1);
      exp_issue_q.push_back(0);
      cyc();
      idle_inputs();
      set_result(1'b1, 4, '1);
      push_res(8'h10, 1'b1);
      cyc();
      idle_inputs();
      mid();
      check("ar_late_result_err", 32'(bus.err_o), 32'h1);
      check("ar_busy_core0", 32'(bus.busy_o), 32'h1);
      cyc();

      check("issue_queue_empty", 32'(exp_issue_q.size()), 32'h0);
      check("result_queue_empty", 32'(exp_res_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fpu_ss_core_arbiter.md
# fpu_ss_core_arbiter

Shares one FPU subsystem between `NB_CORES` cores. It arbitrates the per-core issue requests round-robin into the subsystem's single issue port and tags each accepted request with the winning core index (`core_id_o`, consumed as the subsystem's input core ID). It demultiplexes subsystem results back to the owning core by result core ID. Per-core outstanding-instruction counters throttle cores that exceed `MAX_OUTSTANDING` in-flight instructions.

## Interface
Parameters:
- `NB_CORES`, 8: number of requesting cores, 2..16.
- `MAX_OUTSTANDING`, 4: maximum issued-but-unresulted instructions per core, 1..15.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `core_issue_valid_i` in NB_CORES: per-core issue request.
- `core_issue_ready_o` out NB_CORES: per-core issue accept.
- `ss_issue_valid_o` out 1: request to the subsystem issue port.
- `ss_issue_ready_i` in 1: subsystem accepts the issue.
- `core_id_o` out 32: index of the granted core, zero-extended.
- `ss_result_valid_i` in 1: subsystem result valid.
- `ss_result_core_id_i` in 32: core index that owns the result.
- `ss_result_ready_o` out 1: result accepted.
- `core_result_valid_o` out NB_CORES: per-core result valid.
- `core_result_ready_i` in NB_CORES: per-core result ready.
- `busy_o` out 1: at least one core has a nonzero outstanding count.
- `err_o` out 1: sticky; a result arrived with an illegal core ID.

## Operation
**Eligibility**
- `elig[i] = core_issue_valid_i[i] & (cnt[i] != MAX_OUTSTANDING)`.
- Counter width is `$clog2(MAX_OUTSTANDING+1)`.

**Grant FSM** (states IDLE and LOCKED; reset state IDLE)
- IDLE: choose the first eligible core, searching upward from `rr_ptr` with wrap-around. That core becomes `gnt`, combinationally in the same cycle.
  - `ss_issue_valid_o = |elig`.
  - `core_id_o = gnt`.
  - `core_issue_ready_o[gnt] = ss_issue_ready_i`; all other ready bits are 0.
- IDLE to LOCKED: `ss_issue_valid_o & ~ss_issue_ready_i`. Store `gnt` in `lock_id`.
- LOCKED: the grant is frozen to `lock_id`.
  - `ss_issue_valid_o` stays 1 regardless of the eligibility change caused by other cores.
  - `core_id_o` stays stable.
  - A core that drops `core_issue_valid_i` while locked is a protocol violation. It is not checked, and the grant still holds.
- LOCKED to IDLE: on `ss_issue_ready_i`.

**Issue handshake** (`ss_issue_valid_o & ss_issue_ready_i`, in either state)
- `rr_ptr <= (winner + 1) mod NB_CORES`.
- `cnt[winner]++`.
- Without a handshake, `rr_ptr` does not change.

**Result demux**
- `rid = ss_result_core_id_i`.
- Legal ID (`rid < NB_CORES`):
  - `core_result_valid_o[rid] = ss_result_valid_i`; all others are 0.
  - `ss_result_ready_o = core_result_ready_i[rid]`.
  - On handshake: `cnt[rid]--`.
- Illegal ID (`rid >= NB_CORES`):
  - `ss_result_ready_o = 1`, so the result is dropped.
  - No core valid is raised.
  - `err_o` sets on `ss_result_valid_i` and stays set until reset.
- A result handshake on a core whose `cnt == 0` leaves the counter at 0 (saturates) and sets `err_o`.

**Counters and status**
- Issue and result handshakes to the same core in the same cycle leave that counter unchanged.
- Counters never exceed `MAX_OUTSTANDING`; eligibility masking guarantees this.
- `busy_o = |cnt`, registered view (taken from counter flops).

## Timing
- Reset values:
  - State: IDLE; `rr_ptr = 0`; all `cnt = 0`; `err_o = 0`.
  - `busy_o = 0`.
  - `ss_issue_valid_o`, `core_issue_ready_o`, `core_result_valid_o`, `ss_result_ready_o` = 0 whenever the corresponding inputs are 0.
- Issue path latency is 0 cycles: request to `ss_issue_valid_o` is combinational.
- Result path latency is 0 cycles.
- Combinational paths:
  - `ss_issue_ready_i` to `core_issue_ready_o`.
  - `core_result_ready_i` to `ss_result_ready_o`.
- There is no combinational path from `ss_issue_ready_i` to `ss_issue_valid_o`.
- A counter freed by a result handshake in cycle N makes that core eligible in cycle N+1.
- Reset asserted mid-operation:
  - Everything returns to reset values immediately.
  - In-flight results arriving after reset hit `cnt == 0` and flag `err_o`. Upstream must reset together with this block.

## Test plan
- **Round-robin rotation:** all 8 cores request continuously, subsystem always ready, `MAX_OUTSTANDING = 4`, results returned the next cycle → `core_id_o` sequence is 0,1,2,…,7,0; each core is granted exactly once per 8 cycles.
- **Lock under backpressure:** cores 2 and 5 request, `ss_issue_ready_i = 0` for 3 cycles → `core_id_o = 2` stable for 4 cycles, handshake in cycle 4. The next grant is core 5 even though `rr_ptr` started at 0.
- **Throttle:** only core 3 requests, no results returned → exactly 4 handshakes, then `ss_issue_valid_o = 0`. One result handshake for core 3 → `ss_issue_valid_o = 1` in the next cycle.
- **Simultaneous events:** core 1 has `cnt = 2`; an issue handshake and a result handshake for core 1 occur in the same cycle → `cnt` stays 2 and `busy_o` stays 1.
- **Result routing and error:** a result with `rid = 6` and `core_result_ready_i[6] = 0` for 2 cycles → `core_result_valid_o = 8'h40` held, `ss_result_ready_o = 0` until ready. Then `rid = 9` → `ss_result_ready_o = 1`, no core valid, `err_o = 1` sticky until `rst_ni` is asserted.
- **Async reset:** assert `rst_ni` low mid-LOCKED with nonzero counters → all state clears without a clock edge; after release, the first grant starts from core 0.
